fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the instruction and address width.
REQ-002 The block SHALL have parameter ROM_WORDS, default 256, giving the instruction ROM depth in words.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 Port clk SHALL be an input, 1 bit wide, and SHALL be the rising-edge clock.
REQ-005 Port reset SHALL be an input, 1 bit wide, and SHALL be the synchronous active-low reset.
REQ-006 Port pc SHALL be an input, XLEN bits wide, carrying the byte address to fetch.
REQ-007 Port rom_size SHALL be an input, XLEN bits wide, giving the number of valid program bytes (a multiple of 4).
REQ-008 Port instr_rom SHALL be an input, ROM_WORDS*XLEN bits wide, holding the flattened ROM.
REQ-009 Port instruction SHALL be an output, XLEN bits wide, carrying the registered fetched word.
REQ-010 Port fetch_complete SHALL be an output, 1 bit wide, and SHALL be a registered, sticky end-of-program flag.

Function
REQ-011 Word n of the ROM SHALL occupy instr_rom bits [n*XLEN +: XLEN].
REQ-012 The word SHALL be output exactly as stored, with no byte swap.
REQ-013 The word index SHALL be pc[XLEN-1:2]; pc[1:0] SHALL be ignored, so misaligned addresses round down.
REQ-014 Address in range means pc < rom_size and word index < ROM_WORDS.
REQ-015 On each rising edge while out of reset with the address in range and fetch_complete low, instruction SHALL load ROM word pc>>2.
REQ-016 The output SHALL have one-cycle latency: a pc applied before edge k appears on instruction after edge k.
REQ-017 If fetch_complete is low and the address is not in range (pc >= rom_size, or word index >= ROM_WORDS), then on that edge fetch_complete SHALL go to 1.
REQ-018 In the REQ-017 case, instruction SHALL load 32'h0000_0013, the canonical NOP (addi x0,x0,0).
REQ-019 Once fetch_complete is 1, it SHALL stay 1 and instruction SHALL hold NOP until reset, whatever pc and rom_size do.
REQ-020 With rom_size = 0, the first edge after reset release SHALL assert fetch_complete.
REQ-021 The comparison pc >= rom_size SHALL be unsigned and full XLEN width; pc = 32'hFFFF_FFFC SHALL NOT wrap into the ROM.
REQ-022 The block SHALL be purely combinational from inputs to next state, with no internal pc counter; the caller advances pc while fetch_complete is low.
REQ-023 instr_rom and rom_size SHALL be treated as static after reset; changes mid-run take effect on the next fetch only.

Reset
REQ-024 When reset is low at a rising edge, instruction SHALL become 32'h0000_0013 and fetch_complete SHALL become 0.
REQ-025 Reset SHALL take priority over all other conditions, including a completed program.
REQ-026 A reset asserted mid-run SHALL clear the sticky flag within one edge.
REQ-027 Fetching SHALL resume normally on the first edge with reset high.
REQ-028 The block SHALL use no asynchronous reset and SHALL have no initial-value dependence.

Structure
REQ-029 A shared package SHALL hold XLEN, ROM_WORDS, the NOP constant 32'h0000_0013, and an instruction word typedef.
REQ-030 One sub-module, rom_word_select, SHALL be used: a combinational word mux taking the ROM and an index and returning one word plus an index-in-bounds flag.
REQ-031 fetch_stage SHALL hold only the output registers and the completion logic.

Verification
REQ-032 Basic fetch: ROM words 0..2 = 32'h00500093, 32'h00300113, 32'h002081B3, rom_size = 12, pc stepping 0,4,8 -> instruction shows those words one cycle later, fetch_complete = 0.
REQ-033 End of program: same ROM, pc = 12 -> after one edge fetch_complete = 1 and instruction = 32'h00000013; pc then driven to 0 -> both outputs hold.
REQ-034 Reset priority: reset low while complete -> next edge instruction = 32'h00000013 and fetch_complete = 0; after release with pc = 4 -> 32'h00300113.
REQ-035 Boundary: rom_size = 1024 and pc = 1020 -> word 255 is returned; pc = 1024 -> complete; rom_size = 0 -> complete on the first edge.
REQ-036 Misaligned and overflow: pc = 6 returns word 1; pc = 32'hFFFFFFFC with rom_size = 1024 -> complete, with no wrap to word 255.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared widths, NOP constant and instruction word type for the fetch stage
package fetch_stage_pkg;

  localparam int XLEN      = 32;
  localparam int ROM_WORDS = 256;

  typedef logic [XLEN-1:0] instr_t;

  // addi x0,x0,0 -- what the stage presents when nothing real is being fetched
  localparam instr_t NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch request/response bundle between caller and fetch stage
interface fetch_stage_if #(
  parameter int XLEN      = 32,
  parameter int ROM_WORDS = 256
);

  logic [XLEN-1:0]           pc;
  logic [XLEN-1:0]           rom_size;
  logic [ROM_WORDS*XLEN-1:0] instr_rom;
  logic [XLEN-1:0]           instruction;
  logic                      fetch_complete;

  // caller side: supplies address, program size and ROM image
  modport master (
    output pc,
    output rom_size,
    output instr_rom,
    input  instruction,
    input  fetch_complete
  );

  // fetch stage side
  modport slave (
    input  pc,
    input  rom_size,
    input  instr_rom,
    output instruction,
    output fetch_complete
  );

endinterface

// File: rtl/fetch_stage_rom_word_select.sv
// rtl/fetch_stage_rom_word_select.sv - combinational word mux over the flattened instruction ROM
module rom_word_select #(
  parameter int XLEN      = 32,
  parameter int ROM_WORDS = 256
) (
  input  logic [ROM_WORDS*XLEN-1:0] rom,
  input  logic [XLEN-3:0]           index,
  output logic [XLEN-1:0]           word,
  output logic                      in_bounds
);

  import fetch_stage_pkg::*;

  localparam int SW = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;

  logic [SW-1:0] sel;

  // compare at 64 bits so a ROM depth equal to the full index space cannot truncate to zero
  assign in_bounds = 64'(index) < 64'(ROM_WORDS);

  // low index bits address the ROM; out-of-bounds results are discarded by the caller
  assign sel = index[SW-1:0];

  // pick the addressed word; a zero word stands in whenever the index is out of bounds
  always_comb begin
    word = '0;
    if (in_bounds) begin
      word = rom[32'(sel) * XLEN +: XLEN];
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - registered instruction fetch with sticky end-of-program flag
module fetch_stage #(
  parameter int XLEN      = 32,
  parameter int ROM_WORDS = 256
) (
  input  logic         clk,
  input  logic         reset,
  fetch_stage_if.slave bus
);

  import fetch_stage_pkg::*;

  logic [XLEN-1:0] rom_word;
  logic            index_ok;
  logic            in_range;
  logic [XLEN-1:0] instr_q;
  logic            done_q;

  // pc[1:0] is dropped here, so misaligned addresses round down to their word
  rom_word_select #(
    .XLEN      (XLEN),
    .ROM_WORDS (ROM_WORDS)
  ) u_sel (
    .rom       (bus.instr_rom),
    .index     (bus.pc[XLEN-1:2]),
    .word      (rom_word),
    .in_bounds (index_ok)
  );

  // full-width unsigned compare: addresses near the top of the space must not alias into the ROM
  assign in_range = (bus.pc < bus.rom_size) && index_ok;

  // fetch while running; the first out-of-range address latches completion and parks on NOP
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q <= XLEN'(NOP);
      done_q  <= 1'b0;
    end else if (!done_q) begin
      if (in_range) begin
        instr_q <= rom_word;
      end else begin
        instr_q <= XLEN'(NOP);
        done_q  <= 1'b1;
      end
    end
  end

  assign bus.instruction    = instr_q;
  assign bus.fetch_complete = done_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage against a word-array reference
module tb_fetch_stage;

  localparam int XLEN      = 32;
  localparam int ROM_WORDS = 256;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic clk;
  logic reset;

  fetch_stage_if #(.XLEN(XLEN), .ROM_WORDS(ROM_WORDS)) bus ();

  fetch_stage #(.XLEN(XLEN), .ROM_WORDS(ROM_WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] words [ROM_WORDS];
  logic [31:0] m_instr;
  logic        m_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic load_rom();
    for (int i = 0; i < ROM_WORDS; i++) bus.instr_rom[i*XLEN +: XLEN] = words[i];
  endtask

  // one clock edge with the given reset/pc; reference decides what the outputs must be afterwards
  task automatic tick(input logic rst_n, input logic [31:0] pc_v);
    longint unsigned addr;
    longint unsigned word_no;
    reset  = rst_n;
    bus.pc = pc_v;
    @(posedge clk);
    addr    = longint'(pc_v);
    word_no = addr / 4;
    if (!rst_n) begin
      m_instr = NOP_W;
      m_done  = 1'b0;
    end else if (!m_done) begin
      if (addr < longint'(bus.rom_size) && word_no < ROM_WORDS) begin
        m_instr = words[int'(word_no)];
      end else begin
        m_instr = NOP_W;
        m_done  = 1'b1;
      end
    end
    #1;
    check("instruction", 64'(bus.instruction), 64'(m_instr));
    check("fetch_complete", 64'(bus.fetch_complete), 64'(m_done));
  endtask

  // directed step with a literal expectation on top of the reference
  task automatic tick_e(input logic rst_n, input logic [31:0] pc_v,
                        input logic [31:0] exp_i, input logic exp_d);
    tick(rst_n, pc_v);
    check("directed_instr", 64'(bus.instruction), 64'(exp_i));
    check("directed_done", 64'(bus.fetch_complete), 64'(exp_d));
  endtask

  initial begin
    logic [31:0] pc_r;
    m_instr = NOP_W;
    m_done  = 1'b0;
    reset   = 1'b0;
    bus.pc  = '0;
    for (int i = 0; i < ROM_WORDS; i++) words[i] = $urandom;
    words[0] = 32'h0050_0093;
    words[1] = 32'h0030_0113;
    words[2] = 32'h0020_81B3;
    load_rom();
    bus.rom_size = 32'd12;

    // reset state
    tick_e(1'b0, 32'd0, NOP_W, 1'b0);
    tick_e(1'b0, 32'd4, NOP_W, 1'b0);

    // basic fetch, one-cycle latency
    tick_e(1'b1, 32'd0, 32'h0050_0093, 1'b0);
    tick_e(1'b1, 32'd4, 32'h0030_0113, 1'b0);
    tick_e(1'b1, 32'd8, 32'h0020_81B3, 1'b0);

    // end of program, then sticky hold
    tick_e(1'b1, 32'd12, NOP_W, 1'b1);
    tick_e(1'b1, 32'd0, NOP_W, 1'b1);
    tick_e(1'b1, 32'd4, NOP_W, 1'b1);

    // reset priority and resume
    tick_e(1'b0, 32'd12, NOP_W, 1'b0);
    tick_e(1'b1, 32'd4, 32'h0030_0113, 1'b0);

    // misaligned rounds down
    tick_e(1'b1, 32'd6, 32'h0030_0113, 1'b0);
    tick_e(1'b1, 32'd3, 32'h0050_0093, 1'b0);

    // last ROM word and one past it
    bus.rom_size = 32'd1024;
    tick_e(1'b1, 32'd1020, words[255], 1'b0);
    tick_e(1'b1, 32'd1024, NOP_W, 1'b1);

    // top of address space must not wrap onto word 255
    tick_e(1'b0, 32'd0, NOP_W, 1'b0);
    tick_e(1'b1, 32'd1020, words[255], 1'b0);
    tick_e(1'b1, 32'hFFFF_FFFC, NOP_W, 1'b1);

    // rom_size beyond the ROM: index bound alone ends the program
    bus.rom_size = 32'd4096;
    tick_e(1'b0, 32'd0, NOP_W, 1'b0);
    tick_e(1'b1, 32'd1024, NOP_W, 1'b1);

    // empty program completes on the first edge
    bus.rom_size = 32'd0;
    tick_e(1'b0, 32'd0, NOP_W, 1'b0);
    tick_e(1'b1, 32'd0, NOP_W, 1'b1);

    // randomized run; ROM and size only change while held in reset
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 30) == 0) begin
        for (int i = 0; i < ROM_WORDS; i++) words[i] = $urandom;
        load_rom();
        bus.rom_size = 32'($urandom_range(0, 300)) * 4;
        tick(1'b0, $urandom);
      end else begin
        case ($urandom_range(0, 9))
          0:       pc_r = $urandom;
          1:       pc_r = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
          default: pc_r = 32'($urandom_range(0, 1100));
        endcase
        tick(1'b1, pc_r);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
